alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue/decode controller that drives the single-cycle core's ALU from the producer side of its ALUSel/A/B interface. It accepts one decoded-register-read instruction per handshake, translates opcode/funct3/funct7 into the ALU select code, and registers the operands onto the ALU inputs. It captures the ALU result one cycle later and presents it with rd to writeback over a valid/ready handshake. It covers OP, OP-IMM, LUI and AUIPC; all other opcodes are flagged illegal.

Parameters:
SEL_W, 4, ALU select width; must match the ALU select port.
XLEN, 32, datapath width.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  instruction bundle valid.
in_ready  output  1  controller can accept a bundle.
in_inst  input  XLEN  raw instruction word.
in_pc  input  XLEN  PC of the instruction.
in_rs1  input  XLEN  rs1 register value.
in_rs2  input  XLEN  rs2 register value.
alu_sel  output  SEL_W  ALU operation select (registered).
alu_a  output  XLEN  ALU operand A (registered).
alu_b  output  XLEN  ALU operand B (registered).
alu_out  input  XLEN  ALU combinational result.
out_valid  output  1  result bundle valid.
out_ready  input  1  writeback accepts result.
out_rd  output  5  destination register, inst[11:7].
out_data  output  XLEN  captured result.
out_illegal  output  1  instruction not supported.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; alu_sel, alu_a, alu_b, out_data, out_rd, out_illegal = 0; out_valid=0. in_ready=0 while rst is high. Reset mid-operation discards the in-flight instruction and produces no output.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready: latch rd and decode.
    - Legal: drive alu_sel/alu_a/alu_b, go to EXEC.
    - Illegal: set out_illegal=1, out_data=0, alu_sel=0, go to DONE.
  - EXEC: in_ready=0. Capture out_data<=alu_out, go to DONE.
  - DONE: out_valid=1. out_rd/out_data/out_illegal are held stable until out_ready=1; that cycle clears out_valid and returns to IDLE. No same-cycle re-accept.
- Latency: accept edge to out_valid = 2 cycles (legal) or 1 cycle (illegal). Max throughput is 1 instruction per 3 cycles.
- Select codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI (B<<12), 11 AUIPC (A+(B<<12)).
- OP (0110011): A=rs1, B=rs2. Shifts use B={27'b0,rs2[4:0]}. funct7=0000000 is legal for all funct3. funct7=0100000 is legal only for funct3 000 (SUB) and 101 (SRA). Any other funct7 is illegal.
- OP-IMM (0010011): A=rs1, B=sign-extended inst[31:20]. There is no SUBI: funct3 000 is always ADD.
  - SLTIU: sign-extended immediate, select 4.
  - SLLI: inst[31:25] must be 0000000; B={27'b0,inst[24:20]}.
  - SRLI/SRAI: inst[31:25] must be 0000000 or 0100000; B as for SLLI.
- LUI (0110111): A=0, B={12'b0,inst[31:12]}, select 10.
- AUIPC (0010111): A=in_pc, B={12'b0,inst[31:12]}, select 11.
- Any other opcode, or inst[1:0]!=11: illegal.
- rd=x0 is processed normally; suppression of the register write belongs to writeback.
- alu_sel/alu_a/alu_b hold their last values outside EXEC.
- in_* signals are sampled only on the accept edge. Changes at any other time are ignored.

Test Plan:
- ADD: rs1=5, rs2=7, inst=0x00208033 (add x0? use rd=3: 0x002081B3) -> alu_sel=0, A=5, B=7 in EXEC; 2 cycles after accept out_valid=1, out_rd=3, out_data=12, out_illegal=0.
- SUB/SRA funct7: inst 0x40208133 with rs1=3, rs2=10 -> alu_sel=1, out_data=0xFFFFFFF9. Inst 0x4020D133 with rs2=0x24 -> alu_sel=7, alu_b=4.
- OP-IMM sign-extension: ADDI imm=-1 (inst 0xFFF08093) -> alu_b=0xFFFFFFFF. SRAI inst 0x4030D093 -> alu_sel=7, alu_b=3.
- LUI/AUIPC: LUI inst 0x123450B7 -> alu_sel=10, alu_a=0, alu_b=0x00012345. AUIPC inst 0x00001097 with pc=0x100 -> alu_sel=11, alu_a=0x100, alu_b=1.
- Illegal and backpressure: load opcode 0000011 -> out_valid 1 cycle after accept, out_illegal=1, out_data=0. OP with funct7=0100000, funct3=100 -> illegal. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout; then out_ready=1 -> IDLE next cycle.
- Reset mid-op: assert rst during EXEC -> next cycle all outputs 0, state IDLE, no out_valid pulse. in_ready=1 after rst drops.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/decode controller on the producer side of the ALU.
// It accepts one decoded register-read bundle per handshake, maps
// opcode/funct3/funct7 to an ALU select code and registers the operands
// onto the ALU inputs. One cycle later it captures the ALU result and
// offers it, together with rd, to writeback over a valid/ready handshake.
// Supported classes are OP, OP-IMM, LUI and AUIPC. Any other opcode is
// reported as illegal and is never sent to the ALU.
module alu_issue_ctrl #(
    parameter int SEL_W = 4,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction bundle from register read
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_inst,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    // ALU producer interface
    output logic [SEL_W-1:0]  alu_sel,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_out,
    // result bundle to writeback
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_data,
    output logic              out_illegal
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Major opcodes. The low two bits (11) are part of each constant, so a
    // compressed-style word with inst[1:0] != 11 never matches and falls
    // through to the illegal path.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // ALU select codes; must agree with the ALU's own decode.
    localparam logic [SEL_W-1:0] SEL_ADD   = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_SUB   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_SLL   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_SLT   = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_SLTU  = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_XOR   = SEL_W'(5);
    localparam logic [SEL_W-1:0] SEL_SRL   = SEL_W'(6);
    localparam logic [SEL_W-1:0] SEL_SRA   = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_OR    = SEL_W'(8);
    localparam logic [SEL_W-1:0] SEL_AND   = SEL_W'(9);
    localparam logic [SEL_W-1:0] SEL_LUI   = SEL_W'(10);
    localparam logic [SEL_W-1:0] SEL_AUIPC = SEL_W'(11);

    // ------------------------------------------------------------------
    // Instruction fields and operand forms
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;      // sign-extended I-type immediate
    logic [XLEN-1:0] imm_u;      // U-type payload, right-aligned; the ALU shifts it
    logic [XLEN-1:0] shamt_reg;  // register shift amount, upper bits masked off
    logic [XLEN-1:0] shamt_imm;  // immediate shift amount from inst[24:20]

    assign opcode    = in_inst[6:0];
    assign funct3    = in_inst[14:12];
    assign funct7    = in_inst[31:25];
    assign imm_i     = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_u     = {{(XLEN-20){1'b0}}, in_inst[31:12]};
    assign shamt_reg = {{(XLEN-5){1'b0}}, in_rs2[4:0]};
    assign shamt_imm = {{(XLEN-5){1'b0}}, in_inst[24:20]};

    // ------------------------------------------------------------------
    // Decode results (valid only while a bundle is being accepted)
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] dec_sel;
    logic [XLEN-1:0]  dec_a;
    logic [XLEN-1:0]  dec_b;
    logic             dec_illegal;

    state_t state;
    state_t state_next;
    logic   accept;

    // Translate the instruction into an ALU select code and operands.
    always_comb begin
        // NOTE: every output gets a default before the case tree so that
        // no path leaves a signal unassigned, which would infer a latch.
        dec_sel     = SEL_ADD;
        dec_a       = '0;
        dec_b       = '0;
        dec_illegal = 1'b0;

        unique case (opcode)
            OPC_OP: begin
                dec_a = in_rs1;
                dec_b = in_rs2;
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        F3_ADD:  dec_sel = SEL_ADD;
                        F3_SLL:  begin dec_sel = SEL_SLL; dec_b = shamt_reg; end
                        F3_SLT:  dec_sel = SEL_SLT;
                        F3_SLTU: dec_sel = SEL_SLTU;
                        F3_XOR:  dec_sel = SEL_XOR;
                        F3_SR:   begin dec_sel = SEL_SRL; dec_b = shamt_reg; end
                        F3_OR:   dec_sel = SEL_OR;
                        F3_AND:  dec_sel = SEL_AND;
                        default: dec_illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    dec_sel = SEL_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    dec_sel = SEL_SRA;
                    dec_b   = shamt_reg;
                end else begin
                    dec_illegal = 1'b1;
                end
            end

            OPC_OP_IMM: begin
                // There is no SUBI, so funct3 000 is ADDI whatever inst[31:25] holds.
                dec_a = in_rs1;
                dec_b = imm_i;
                unique case (funct3)
                    F3_ADD:  dec_sel = SEL_ADD;
                    F3_SLT:  dec_sel = SEL_SLT;
                    F3_SLTU: dec_sel = SEL_SLTU;   // immediate is still sign-extended
                    F3_XOR:  dec_sel = SEL_XOR;
                    F3_OR:   dec_sel = SEL_OR;
                    F3_AND:  dec_sel = SEL_AND;
                    F3_SLL: begin
                        dec_b = shamt_imm;
                        if (funct7 == F7_BASE) dec_sel     = SEL_SLL;
                        else                   dec_illegal = 1'b1;
                    end
                    F3_SR: begin
                        dec_b = shamt_imm;
                        if (funct7 == F7_BASE)     dec_sel     = SEL_SRL;
                        else if (funct7 == F7_ALT) dec_sel     = SEL_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end

            OPC_LUI: begin
                dec_sel = SEL_LUI;
                dec_a   = '0;
                dec_b   = imm_u;
            end

            OPC_AUIPC: begin
                dec_sel = SEL_AUIPC;
                dec_a   = in_pc;
                dec_b   = imm_u;
            end

            default: dec_illegal = 1'b1;
        endcase

        // Illegal bundles never reach the ALU, so report a neutral select.
        if (dec_illegal) begin
            dec_sel = SEL_ADD;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    // Gated by rst so that no result handshake can complete while the
    // in-flight instruction is being discarded.
    assign out_valid = (state == DONE) && !rst;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one accept, one execute cycle, then hold until drained.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = dec_illegal ? DONE : EXEC;
                end
            end
            EXEC: state_next = DONE;
            DONE: begin
                // Returning to IDLE here, rather than re-accepting, keeps the
                // result stable for exactly one handshake.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Operand and result registers: loaded on accept, result captured in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_sel     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            out_rd      <= '0;
            out_data    <= '0;
            out_illegal <= 1'b0;
        end else begin
            if (accept) begin
                out_rd <= in_inst[11:7];
                if (dec_illegal) begin
                    // Operands keep their previous values; only the select clears.
                    out_illegal <= 1'b1;
                    out_data    <= '0;
                    alu_sel     <= '0;
                end else begin
                    out_illegal <= 1'b0;
                    alu_sel     <= dec_sel;
                    alu_a       <= dec_a;
                    alu_b       <= dec_b;
                end
            end
            if (state == EXEC) begin
                out_data <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl. A behavioural ALU
// closes the loop. Expected writeback bundles go into a scoreboard queue
// when each instruction is driven and are popped when out_valid appears.
module tb_alu_issue_ctrl;

    localparam int SEL_W = 4;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_inst;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [SEL_W-1:0] alu_sel;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_out;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_rd;
    logic [XLEN-1:0]  out_data;
    logic             out_illegal;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    alu_issue_ctrl #(.SEL_W(SEL_W), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .alu_sel     (alu_sel),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_data    (out_data),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural single-cycle ALU that the controller drives.
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            4'd0:  alu_out = alu_a + alu_b;
            4'd1:  alu_out = alu_a - alu_b;
            4'd2:  alu_out = alu_a << alu_b[4:0];
            4'd3:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'd4:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'd5:  alu_out = alu_a ^ alu_b;
            4'd6:  alu_out = alu_a >> alu_b[4:0];
            4'd7:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd8:  alu_out = alu_a | alu_b;
            4'd9:  alu_out = alu_a & alu_b;
            4'd10: alu_out = alu_b << 12;
            4'd11: alu_out = alu_a + (alu_b << 12);
            default: alu_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one bundle, check ALU operands in EXEC, latency, the popped
    // scoreboard entry, and stability under `hold` cycles of backpressure.
    task automatic run_op(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [3:0] e_sel, input logic [31:0] e_a, input logic [31:0] e_b,
                          input logic [4:0] e_rd, input logic [31:0] e_data, input logic e_ill,
                          input int hold);
        exp_t e;
        exp_t got;
        int   cycles;
        e.rd = e_rd;
        e.data = e_data;
        e.illegal = e_ill;
        sb.push_back(e);

        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        in_rs1   = rs1;
        in_rs2   = rs2;
        tick();
        // Inputs are ignored outside the accept edge; scramble them.
        in_valid = 1'b0;
        in_inst  = $urandom;
        in_pc    = $urandom;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        cycles   = 1;
        if (!e_ill) begin
            check({tag, ".alu_sel"}, 32'(alu_sel), 32'(e_sel));
            check({tag, ".alu_a"}, alu_a, e_a);
            check({tag, ".alu_b"}, alu_b, e_b);
            check({tag, ".in_ready_exec"}, 32'(in_ready), 32'd0);
        end
        while (!out_valid && cycles < 8) begin
            tick();
            cycles++;
        end
        check({tag, ".latency"}, 32'(cycles), e_ill ? 32'd1 : 32'd2);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check({tag, ".out_rd"}, 32'(out_rd), 32'(got.rd));
            check({tag, ".out_data"}, out_data, got.data);
            check({tag, ".out_illegal"}, 32'(out_illegal), 32'(got.illegal));
            if (e_ill) begin
                check({tag, ".alu_sel_cleared"}, 32'(alu_sel), 32'd0);
            end
            for (int i = 0; i < hold; i++) begin
                tick();
                check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, ".hold_rd"}, 32'(out_rd), 32'(got.rd));
                check({tag, ".hold_data"}, out_data, got.data);
                check({tag, ".hold_illegal"}, 32'(out_illegal), 32'(got.illegal));
                check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        check({tag, ".drained_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".drained_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        // Reset state.
        check("rst.alu_sel", 32'(alu_sel), 32'd0);
        check("rst.alu_a", alu_a, 32'd0);
        check("rst.alu_b", alu_b, 32'd0);
        check("rst.out_data", out_data, 32'd0);
        check("rst.out_rd", 32'(out_rd), 32'd0);
        check("rst.out_illegal", 32'(out_illegal), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();

        //        tag      inst          pc          rs1           rs2          sel    A             B             rd  data          ill hold
        run_op("add",   32'h002081B3, 32'h0,     32'd5,        32'd7,        4'd0,  32'd5,        32'd7,        3,  32'd12,       0, 0);
        run_op("sub",   32'h40208133, 32'h0,     32'd3,        32'd10,       4'd1,  32'd3,        32'd10,       2,  32'hFFFFFFF9, 0, 1);
        run_op("sra",   32'h4020D133, 32'h0,     32'h80000000, 32'h24,       4'd7,  32'h80000000, 32'd4,        2,  32'hF8000000, 0, 0);
        run_op("sll",   32'h002091B3, 32'h0,     32'd1,        32'h21,       4'd2,  32'd1,        32'd1,        3,  32'd2,        0, 0);
        run_op("addi",  32'hFFF08093, 32'h0,     32'd10,       32'd0,        4'd0,  32'd10,       32'hFFFFFFFF, 1,  32'd9,        0, 0);
        run_op("srai",  32'h4030D093, 32'h0,     32'hFFFFFF00, 32'd0,        4'd7,  32'hFFFFFF00, 32'd3,        1,  32'hFFFFFFE0, 0, 0);
        run_op("sltiu", 32'hFFF0B093, 32'h0,     32'd5,        32'd0,        4'd4,  32'd5,        32'hFFFFFFFF, 1,  32'd1,        0, 0);
        run_op("lui",   32'h123450B7, 32'h0,     32'hDEADBEEF, 32'h0,        4'd10, 32'd0,        32'h00012345, 1,  32'h12345000, 0, 0);
        run_op("auipc", 32'h00001097, 32'h100,   32'hDEADBEEF, 32'h0,        4'd11, 32'h100,      32'd1,        1,  32'h00001100, 0, 0);
        run_op("load",  32'h00002083, 32'h0,     32'd1,        32'd2,        4'd0,  32'd0,        32'd0,        1,  32'd0,        1, 5);
        run_op("f7alt", 32'h4020C133, 32'h0,     32'd1,        32'd2,        4'd0,  32'd0,        32'd0,        2,  32'd0,        1, 0);
        run_op("slli7", 32'h02009093, 32'h0,     32'd1,        32'd2,        4'd0,  32'd0,        32'd0,        1,  32'd0,        1, 0);
        run_op("lo2b",  32'h002081B1, 32'h0,     32'd1,        32'd2,        4'd0,  32'd0,        32'd0,        3,  32'd0,        1, 0);

        // Reset during EXEC discards the instruction.
        check("rmid.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_inst  = 32'h002081B3;
        in_rs1   = 32'd5;
        in_rs2   = 32'd7;
        tick();
        in_valid = 1'b0;
        check("rmid.exec_a", alu_a, 32'd5);
        rst = 1'b1;
        tick();
        check("rmid.alu_sel", 32'(alu_sel), 32'd0);
        check("rmid.alu_a", alu_a, 32'd0);
        check("rmid.alu_b", alu_b, 32'd0);
        check("rmid.out_data", out_data, 32'd0);
        check("rmid.out_rd", 32'(out_rd), 32'd0);
        check("rmid.out_illegal", 32'(out_illegal), 32'd0);
        check("rmid.out_valid", 32'(out_valid), 32'd0);
        check("rmid.in_ready_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rmid.in_ready_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rmid.no_valid", 32'(out_valid), 32'd0);
        end

        run_op("xor",   32'h0020C1B3, 32'h0,     32'h0000F0F0, 32'h0000FF00, 4'd5,  32'h0000F0F0, 32'h0000FF00, 3,  32'h00000FF0, 0, 2);

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
